// File: rtl/chmap_fill_arbiter.sv
// Port-A arbiter for vgachargen: host request/response path plus an optional
// screen fill engine, compiled in with `define VGACHARGEN_FILL_EN.
`timescale 1ns / 1ps

module chmap_fill_arbiter #(
  parameter int unsigned SCREEN_WORDS      = 2400,
  parameter int unsigned CH_MAP_ADDR_WIDTH = 12,
  parameter int unsigned CH_T_ADDR_WIDTH   = 7,
  parameter int unsigned CH_T_DATA_WIDTH   = 64
) (
  input  logic                         clk_i,
  input  logic                         arstn_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_we_i,
  input  logic [1:0]                   req_sel_i,
  input  logic [CH_MAP_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [CH_T_DATA_WIDTH-1:0]   req_wdata_i,
  output logic                         rsp_valid_o,
  output logic [CH_T_DATA_WIDTH-1:0]   rsp_rdata_o,
  input  logic                         fill_start_i,
  input  logic [7:0]                   fill_ch_i,
  input  logic [7:0]                   fill_col_i,
  output logic                         fill_busy_o,
  output logic                         fill_done_o,
  output logic [CH_MAP_ADDR_WIDTH-1:0] ch_map_addr_o,
  output logic [7:0]                   ch_map_data_o,
  output logic                         ch_map_wen_o,
  output logic [CH_MAP_ADDR_WIDTH-1:0] col_map_addr_o,
  output logic [7:0]                   col_map_data_o,
  output logic                         col_map_wen_o,
  output logic [CH_T_ADDR_WIDTH-1:0]   ch_t_rw_addr_o,
  output logic [CH_T_DATA_WIDTH-1:0]   ch_t_rw_data_o,
  output logic                         ch_t_rw_wen_o,
  input  logic [7:0]                   ch_map_rdata_i,
  input  logic [7:0]                   col_map_rdata_i,
  input  logic [CH_T_DATA_WIDTH-1:0]   ch_t_rw_rdata_i
);

  logic       grant_host;
  logic       rd_q1, rsp_valid_q;
  logic [1:0] sel_q1, sel_q2;

`ifdef VGACHARGEN_FILL_EN
  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e                       state_q;
  logic                         last_fill_q;
  logic [CH_MAP_ADDR_WIDTH-1:0] cnt_q;
  logic [7:0]                   fill_ch_q, fill_col_q;
  logic                         fill_busy_q, fill_done_q;
  logic                         grant_fill, cnt_last;

  // Host wins when the fill is idle or the fill took the previous grant.
  assign req_ready_o = (state_q == StIdle) || last_fill_q;
  assign grant_host  = req_valid_i && req_ready_o;
  assign grant_fill  = (state_q == StFill) && !grant_host;
  assign cnt_last    = (cnt_q == CH_MAP_ADDR_WIDTH'(SCREEN_WORDS - 1));

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= StIdle;
      last_fill_q <= 1'b1;
      cnt_q       <= '0;
      fill_ch_q   <= '0;
      fill_col_q  <= '0;
      fill_busy_q <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      fill_done_q <= 1'b0;
      if (grant_host) begin
        last_fill_q <= 1'b0;
      end else if (grant_fill) begin
        last_fill_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (fill_start_i) begin
            state_q     <= StFill;
            fill_busy_q <= 1'b1;
            cnt_q       <= '0;
            fill_ch_q   <= fill_ch_i;
            fill_col_q  <= fill_col_i;
            last_fill_q <= 1'b1;
          end
        end
        StFill: begin
          if (grant_fill) begin
            cnt_q <= cnt_q + CH_MAP_ADDR_WIDTH'(1);
            if (cnt_last) begin
              state_q     <= StIdle;
              fill_busy_q <= 1'b0;
              fill_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fill_busy_o = fill_busy_q;
  assign fill_done_o = fill_done_q;
`else
  logic unused_fill;

  assign unused_fill = ^{fill_start_i, fill_ch_i, fill_col_i};
  assign req_ready_o = 1'b1;
  assign grant_host  = req_valid_i;
  assign fill_busy_o = 1'b0;
  assign fill_done_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      ch_map_addr_o  <= '0;
      ch_map_data_o  <= '0;
      ch_map_wen_o   <= 1'b0;
      col_map_addr_o <= '0;
      col_map_data_o <= '0;
      col_map_wen_o  <= 1'b0;
      ch_t_rw_addr_o <= '0;
      ch_t_rw_data_o <= '0;
      ch_t_rw_wen_o  <= 1'b0;
      rd_q1          <= 1'b0;
      rsp_valid_q    <= 1'b0;
      sel_q1         <= '0;
      sel_q2         <= '0;
    end else begin
      ch_map_wen_o  <= 1'b0;
      col_map_wen_o <= 1'b0;
      ch_t_rw_wen_o <= 1'b0;
      rd_q1         <= grant_host && !req_we_i;
      sel_q1        <= req_sel_i;
      rsp_valid_q   <= rd_q1;
      sel_q2        <= sel_q1;
      if (grant_host) begin
        case (req_sel_i)
          2'd0: begin
            ch_map_addr_o <= req_addr_i;
            ch_map_wen_o  <= req_we_i;
            if (req_we_i) ch_map_data_o <= req_wdata_i[7:0];
          end
          2'd1: begin
            col_map_addr_o <= req_addr_i;
            col_map_wen_o  <= req_we_i;
            if (req_we_i) col_map_data_o <= req_wdata_i[7:0];
          end
          2'd2: begin
            ch_t_rw_addr_o <= req_addr_i[CH_T_ADDR_WIDTH-1:0];
            ch_t_rw_wen_o  <= req_we_i;
            if (req_we_i) ch_t_rw_data_o <= req_wdata_i;
          end
          default: ;
        endcase
      end
`ifdef VGACHARGEN_FILL_EN
      if (grant_fill) begin
        ch_map_addr_o  <= cnt_q;
        ch_map_data_o  <= fill_ch_q;
        ch_map_wen_o   <= 1'b1;
        col_map_addr_o <= cnt_q;
        col_map_data_o <= fill_col_q;
        col_map_wen_o  <= 1'b1;
      end
`endif
    end
  end

  assign rsp_valid_o = rsp_valid_q;

  // Memory read data lands two cycles after accept; reserved target reads as 0.
  always_comb begin
    rsp_rdata_o = '0;
    if (rsp_valid_q) begin
      case (sel_q2)
        2'd0:    rsp_rdata_o = CH_T_DATA_WIDTH'(ch_map_rdata_i);
        2'd1:    rsp_rdata_o = CH_T_DATA_WIDTH'(col_map_rdata_i);
        2'd2:    rsp_rdata_o = ch_t_rw_rdata_i;
        default: rsp_rdata_o = '0;
      endcase
    end
  end

endmodule
